// File: rtl/mem_stage.sv
// Memory stage of the pipeline. It issues data-memory requests for aligned
// loads and stores, waits for the handshake with a bounded timeout, resolves
// branches, and drives the MEM/WB pipeline register.
module mem_stage #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_valid,
    input  logic [1:0]  i_WB,
    input  logic        i_Branch,
    input  logic        i_MemWrite,
    input  logic        i_MemRead,
    input  logic [31:0] i_BranchInst,
    input  logic        i_ZeroFlag,
    input  logic [31:0] i_ALUresult,
    input  logic [31:0] i_Dato2,
    input  logic [4:0]  i_DirWriteReg,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        O_PCSrc,
    output logic [31:0] O_BranchTarget,
    output logic        O_Stall,
    output logic        O_Valid,
    output logic [1:0]  O_WB,
    output logic [31:0] O_ReadData,
    output logic [31:0] O_ALUresult,
    output logic [4:0]  O_DirWriteReg,
    output logic        O_MemErr
);

    typedef enum logic {IDLE, ACCESS} state_t;

    localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

    state_t      state_reg, state_next;
    logic [7:0]  cnt_reg, cnt_next;
    // Request captured when the access starts; held stable until it ends.
    logic        we_reg, we_next;
    logic [31:0] addr_reg, addr_next;
    logic [31:0] wdata_reg, wdata_next;
    logic [1:0]  wb_cap_reg, wb_cap_next;
    logic [4:0]  dir_cap_reg, dir_cap_next;
    // MEM/WB pipeline register.
    logic        valid_reg, valid_next;
    logic [1:0]  wb_reg, wb_next;
    logic [31:0] rdata_reg, rdata_next;
    logic [31:0] alu_reg, alu_next;
    logic [4:0]  dir_reg, dir_next;
    logic        err_reg, err_next;

    logic        stall;
    logic        mem_op;
    logic        misaligned;

    assign mem_op     = i_valid & (i_MemRead | i_MemWrite);
    assign misaligned = |i_ALUresult[1:0];

    // Next-state, captured request and MEM/WB contents for this cycle.
    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        we_next      = we_reg;
        addr_next    = addr_reg;
        wdata_next   = wdata_reg;
        wb_cap_next  = wb_cap_reg;
        dir_cap_next = dir_cap_reg;
        valid_next   = 1'b0;
        wb_next      = 2'b00;
        rdata_next   = 32'd0;
        alu_next     = 32'd0;
        dir_next     = 5'd0;
        err_next     = 1'b0;
        stall        = 1'b0;
        case (state_reg)
            IDLE: begin
                if (mem_op && !misaligned) begin
                    // Start the access; MEM/WB takes a bubble meanwhile.
                    stall        = 1'b1;
                    state_next   = ACCESS;
                    cnt_next     = 8'd1;
                    we_next      = i_MemWrite;
                    addr_next    = i_ALUresult;
                    wdata_next   = i_Dato2;
                    wb_cap_next  = i_WB;
                    dir_cap_next = i_DirWriteReg;
                end else if (mem_op) begin
                    // Misaligned: never reaches memory, writeback suppressed.
                    valid_next = 1'b1;
                    alu_next   = i_ALUresult;
                    dir_next   = i_DirWriteReg;
                    err_next   = 1'b1;
                end else begin
                    valid_next = i_valid;
                    wb_next    = i_WB;
                    alu_next   = i_ALUresult;
                    dir_next   = i_DirWriteReg;
                end
            end
            ACCESS: begin
                if (mem_ack) begin
                    // Acknowledge takes priority over a simultaneous timeout.
                    state_next = IDLE;
                    cnt_next   = 8'd0;
                    valid_next = 1'b1;
                    wb_next    = wb_cap_reg;
                    rdata_next = we_reg ? 32'd0 : mem_rdata;
                    alu_next   = addr_reg;
                    dir_next   = dir_cap_reg;
                end else if (cnt_reg >= TIMEOUT) begin
                    state_next = IDLE;
                    cnt_next   = 8'd0;
                    valid_next = 1'b1;
                    alu_next   = addr_reg;
                    dir_next   = dir_cap_reg;
                    err_next   = 1'b1;
                end else begin
                    stall    = 1'b1;
                    cnt_next = cnt_reg + 8'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State, request and MEM/WB registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            cnt_reg     <= 8'd0;
            we_reg      <= 1'b0;
            addr_reg    <= 32'd0;
            wdata_reg   <= 32'd0;
            wb_cap_reg  <= 2'b00;
            dir_cap_reg <= 5'd0;
            valid_reg   <= 1'b0;
            wb_reg      <= 2'b00;
            rdata_reg   <= 32'd0;
            alu_reg     <= 32'd0;
            dir_reg     <= 5'd0;
            err_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            we_reg      <= we_next;
            addr_reg    <= addr_next;
            wdata_reg   <= wdata_next;
            wb_cap_reg  <= wb_cap_next;
            dir_cap_reg <= dir_cap_next;
            valid_reg   <= valid_next;
            wb_reg      <= wb_next;
            rdata_reg   <= rdata_next;
            alu_reg     <= alu_next;
            dir_reg     <= dir_next;
            err_reg     <= err_next;
        end
    end

    assign mem_req        = (state_reg == ACCESS);
    assign mem_we         = we_reg;
    assign mem_addr       = addr_reg;
    assign mem_wdata      = wdata_reg;
    assign O_Stall        = stall & ~rst;
    assign O_PCSrc        = i_valid & i_Branch & i_ZeroFlag & ~O_Stall & ~rst;
    assign O_BranchTarget = i_BranchInst;
    assign O_Valid        = valid_reg;
    assign O_WB           = wb_reg;
    assign O_ReadData     = rdata_reg;
    assign O_ALUresult    = alu_reg;
    assign O_DirWriteReg  = dir_reg;
    assign O_MemErr       = err_reg;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: per-scenario tasks, MEM/WB results
// predicted into a scoreboard queue when stimulus is driven.
module tb_mem_stage;

    logic        clk;
    logic        rst;
    logic        i_valid;
    logic [1:0]  i_WB;
    logic        i_Branch, i_MemWrite, i_MemRead, i_ZeroFlag;
    logic [31:0] i_BranchInst, i_ALUresult, i_Dato2;
    logic [4:0]  i_DirWriteReg;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        O_PCSrc, O_Stall, O_Valid, O_MemErr;
    logic [31:0] O_BranchTarget, O_ReadData, O_ALUresult;
    logic [1:0]  O_WB;
    logic [4:0]  O_DirWriteReg;

    typedef struct packed {
        logic        valid;
        logic [1:0]  wb;
        logic [31:0] rdata;
        logic [31:0] alu;
        logic [4:0]  dir;
        logic        err;
    } mwb_t;

    mwb_t obs;
    mwb_t e;
    mwb_t exp_q[$];
    int   n_checks = 0;
    int   n_fail = 0;

    assign obs = {O_Valid, O_WB, O_ReadData, O_ALUresult, O_DirWriteReg, O_MemErr};

    mem_stage #(.MEM_TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .i_valid(i_valid), .i_WB(i_WB), .i_Branch(i_Branch),
        .i_MemWrite(i_MemWrite), .i_MemRead(i_MemRead),
        .i_BranchInst(i_BranchInst), .i_ZeroFlag(i_ZeroFlag),
        .i_ALUresult(i_ALUresult), .i_Dato2(i_Dato2), .i_DirWriteReg(i_DirWriteReg),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .O_PCSrc(O_PCSrc), .O_BranchTarget(O_BranchTarget), .O_Stall(O_Stall),
        .O_Valid(O_Valid), .O_WB(O_WB), .O_ReadData(O_ReadData),
        .O_ALUresult(O_ALUresult), .O_DirWriteReg(O_DirWriteReg), .O_MemErr(O_MemErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] wb, input logic br, input logic zero,
                         input logic mw, input logic mr, input logic [31:0] alu,
                         input logic [31:0] d2, input logic [4:0] dir);
        i_valid       = v;
        i_WB          = wb;
        i_Branch      = br;
        i_ZeroFlag    = zero;
        i_MemWrite    = mw;
        i_MemRead     = mr;
        i_ALUresult   = alu;
        i_Dato2       = d2;
        i_DirWriteReg = dir;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        mem_ack = 1'b0;
        mem_rdata = 32'd0;
        i_BranchInst = 32'h0000_0400;
        drive(1, 2'b11, 1, 1, 0, 1, 32'h100, 32'h0, 5'd1);
        tick();
        tick();
        n_checks++;
        if ({O_Stall, O_PCSrc} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_stall_pcsrc: got %b expected 00", {O_Stall, O_PCSrc});
        end
        n_checks++;
        if ({mem_req, mem_we, mem_addr, mem_wdata} !== 66'd0) begin
            n_fail++;
            $display("FAIL reset_mem_if: got req=%b we=%b addr=%h wdata=%h expected all 0",
                     mem_req, mem_we, mem_addr, mem_wdata);
        end
        n_checks++;
        if (obs !== mwb_t'(0)) begin
            n_fail++;
            $display("FAIL reset_mwb: got %h expected 0", obs);
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        tick();
        $display("reset: done");
    endtask

    task automatic test_alu();
        drive(1, 2'b01, 0, 0, 0, 0, 32'h10, 32'h0, 5'd5);
        exp_q.push_back('{valid: 1'b1, wb: 2'b01, rdata: 32'd0, alu: 32'h10, dir: 5'd5, err: 1'b0});
        #1;
        n_checks++;
        if ({O_Stall, mem_req} !== 2'b00) begin
            n_fail++;
            $display("FAIL alu_stall: got stall=%b req=%b expected 0 0", O_Stall, mem_req);
        end
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        e = exp_q.pop_front();
        n_checks++;
        if (obs !== e) begin
            n_fail++;
            $display("FAIL alu_mwb: got %h expected %h", obs, e);
        end
        $display("alu: alu=%h dir=%0d valid=%b", O_ALUresult, O_DirWriteReg, O_Valid);
    endtask

    task automatic test_load();
        int stalls = 0;
        int reqs = 0;
        drive(1, 2'b11, 0, 0, 0, 1, 32'h100, 32'h0, 5'd7);
        exp_q.push_back('{valid: 1'b1, wb: 2'b11, rdata: 32'hDEADBEEF, alu: 32'h100, dir: 5'd7, err: 1'b0});
        for (int k = 0; k <= 4; k++) begin
            if (k == 4) begin
                mem_ack = 1'b1;
                mem_rdata = 32'hDEADBEEF;
            end
            #1;
            if (O_Stall) stalls++;
            if (mem_req) reqs++;
            if (k == 2) begin
                n_checks++;
                if ({mem_addr, mem_we, O_Valid, O_WB} !== {32'h100, 1'b0, 1'b0, 2'b00}) begin
                    n_fail++;
                    $display("FAIL load_access: got addr=%h we=%b valid=%b wb=%b expected 100 0 0 00",
                             mem_addr, mem_we, O_Valid, O_WB);
                end
            end
            tick();
        end
        mem_ack = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        e = exp_q.pop_front();
        n_checks++;
        if (obs !== e) begin
            n_fail++;
            $display("FAIL load_mwb: got %h expected %h", obs, e);
        end
        n_checks++;
        if (stalls != 4 || reqs != 4 || mem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL load_timing: got stalls=%0d reqs=%0d req_after=%b expected 4 4 0",
                     stalls, reqs, mem_req);
        end
        $display("load: rdata=%h wb=%b stalls=%0d", O_ReadData, O_WB, stalls);
    endtask

    task automatic test_misaligned();
        drive(1, 2'b01, 0, 0, 1, 0, 32'h202, 32'h1234, 5'd3);
        exp_q.push_back('{valid: 1'b1, wb: 2'b00, rdata: 32'd0, alu: 32'h202, dir: 5'd3, err: 1'b1});
        #1;
        n_checks++;
        if ({O_Stall, mem_req} !== 2'b00) begin
            n_fail++;
            $display("FAIL misalign_stall: got stall=%b req=%b expected 0 0", O_Stall, mem_req);
        end
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        e = exp_q.pop_front();
        n_checks++;
        if (obs !== e || mem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL misalign_mwb: got %h req=%b expected %h req=0", obs, mem_req, e);
        end
        tick();
        n_checks++;
        if (O_MemErr !== 1'b0) begin
            n_fail++;
            $display("FAIL misalign_pulse: got err=%b expected 0", O_MemErr);
        end
        $display("misaligned store: err pulse seen, wb=00");
    endtask

    task automatic run_timeout(input logic ack_last, input logic [31:0] addr, input logic [4:0] dir);
        int stalls = 0;
        int reqs = 0;
        drive(1, 2'b11, 0, 0, 0, 1, addr, 32'h0, dir);
        if (ack_last)
            exp_q.push_back('{valid: 1'b1, wb: 2'b11, rdata: 32'h1234_5678, alu: addr, dir: dir, err: 1'b0});
        else
            exp_q.push_back('{valid: 1'b1, wb: 2'b00, rdata: 32'd0, alu: addr, dir: dir, err: 1'b1});
        for (int k = 0; k <= 4; k++) begin
            if (k == 4 && ack_last) begin
                mem_ack = 1'b1;
                mem_rdata = 32'h1234_5678;
            end
            #1;
            if (O_Stall) stalls++;
            if (mem_req) reqs++;
            tick();
        end
        mem_ack = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        e = exp_q.pop_front();
        n_checks++;
        if (obs !== e) begin
            n_fail++;
            $display("FAIL timeout_mwb(ack=%b): got %h expected %h", ack_last, obs, e);
        end
        for (int k = 0; k < 3; k++) begin
            if (mem_req) reqs++;
            tick();
        end
        n_checks++;
        if (stalls != 4 || reqs != 4 || O_MemErr !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_timing(ack=%b): got stalls=%0d reqs=%0d err=%b expected 4 4 0",
                     ack_last, stalls, reqs, O_MemErr);
        end
        $display("timeout ack=%b: reqs=%0d stalls=%0d", ack_last, reqs, stalls);
    endtask

    task automatic test_timeout();
        run_timeout(1'b0, 32'h300, 5'd9);
        run_timeout(1'b1, 32'h304, 5'd10);
    endtask

    task automatic test_branch();
        i_BranchInst = 32'h0000_0400;
        drive(1, 2'b00, 1, 1, 0, 0, 32'h0, 32'h0, 5'd0);
        #1;
        n_checks++;
        if ({O_PCSrc, O_BranchTarget} !== {1'b1, 32'h400}) begin
            n_fail++;
            $display("FAIL branch_taken: got pcsrc=%b target=%h expected 1 400", O_PCSrc, O_BranchTarget);
        end
        i_ZeroFlag = 1'b0;
        #1;
        n_checks++;
        if (O_PCSrc !== 1'b0) begin
            n_fail++;
            $display("FAIL branch_not_taken: got pcsrc=%b expected 0", O_PCSrc);
        end
        exp_q.push_back('{valid: 1'b1, wb: 2'b00, rdata: 32'd0, alu: 32'd0, dir: 5'd0, err: 1'b0});
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        e = exp_q.pop_front();
        n_checks++;
        if (obs !== e) begin
            n_fail++;
            $display("FAIL branch_mwb: got %h expected %h", obs, e);
        end
        $display("branch: target=%h", O_BranchTarget);
    endtask

    task automatic test_ack_idle();
        mem_ack = 1'b1;
        mem_rdata = 32'hFFFF_FFFF;
        tick();
        mem_ack = 1'b0;
        n_checks++;
        if ({mem_req, O_Valid, O_ReadData} !== 34'd0) begin
            n_fail++;
            $display("FAIL ack_idle: got req=%b valid=%b rdata=%h expected 0 0 0", mem_req, O_Valid, O_ReadData);
        end
        $display("ack in idle: ignored");
    endtask

    task automatic test_back_to_back();
        drive(1, 2'b11, 0, 0, 0, 1, 32'h40, 32'h0, 5'd1);
        exp_q.push_back('{valid: 1'b1, wb: 2'b11, rdata: 32'h0000_000A, alu: 32'h40, dir: 5'd1, err: 1'b0});
        tick();
        mem_ack = 1'b1;
        mem_rdata = 32'h0000_000A;
        #1;
        n_checks++;
        if ({O_Stall, mem_req} !== 2'b01) begin
            n_fail++;
            $display("FAIL b2b_ack_stall: got stall=%b req=%b expected 0 1", O_Stall, mem_req);
        end
        tick();
        mem_ack = 1'b0;
        drive(1, 2'b00, 0, 0, 1, 1, 32'h48, 32'hCAFE_F00D, 5'd0);
        exp_q.push_back('{valid: 1'b1, wb: 2'b00, rdata: 32'd0, alu: 32'h48, dir: 5'd0, err: 1'b0});
        e = exp_q.pop_front();
        n_checks++;
        if (obs !== e) begin
            n_fail++;
            $display("FAIL b2b_first: got %h expected %h", obs, e);
        end
        tick();
        n_checks++;
        if ({mem_req, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 32'h48, 32'hCAFE_F00D}) begin
            n_fail++;
            $display("FAIL b2b_store_req: got req=%b we=%b addr=%h wdata=%h expected 1 1 48 cafef00d",
                     mem_req, mem_we, mem_addr, mem_wdata);
        end
        mem_ack = 1'b1;
        mem_rdata = 32'h5555_5555;
        tick();
        mem_ack = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        e = exp_q.pop_front();
        n_checks++;
        if (obs !== e) begin
            n_fail++;
            $display("FAIL b2b_second: got %h expected %h", obs, e);
        end
        $display("back-to-back: load then store, 2 cycles each");
    endtask

    task automatic test_reset_access();
        drive(1, 2'b11, 0, 0, 0, 1, 32'h500, 32'h0, 5'd4);
        tick();
        tick();
        rst = 1'b1;
        #1;
        n_checks++;
        if (O_Stall !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_access_stall: got %b expected 0", O_Stall);
        end
        tick();
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        n_checks++;
        if ({mem_req, mem_we, mem_addr, mem_wdata} !== 66'd0 || obs !== mwb_t'(0)) begin
            n_fail++;
            $display("FAIL rst_access_clear: got req=%b addr=%h mwb=%h expected 0", mem_req, mem_addr, obs);
        end
        mem_ack = 1'b1;
        mem_rdata = 32'h0000_0BAD;
        tick();
        mem_ack = 1'b0;
        n_checks++;
        if (obs !== mwb_t'(0) || mem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_late_ack: got mwb=%h req=%b expected 0 0", obs, mem_req);
        end
        $display("reset during access: request dropped, late ack ignored");
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load();
        test_misaligned();
        test_timeout();
        test_branch();
        test_ack_idle();
        test_back_to_back();
        test_reset_access();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty: got %0d entries expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter MEM_TIMEOUT, default 255: max ACCESS cycles waiting for mem_ack before abort (8-bit counter range, 1..255).
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 i_valid  in  1  EX/MEM contents hold a real instruction.
REQ-005 i_WB  in  2  writeback controls; bit0 RegWrite, bit1 MemtoReg.
REQ-006 i_Branch, i_MemWrite, i_MemRead  in  1 each  memory-stage controls.
REQ-007 i_BranchInst  in  32  branch target address.
REQ-008 i_ZeroFlag  in  1  ALU zero result.
REQ-009 i_ALUresult  in  32  memory address or ALU result.
REQ-010 i_Dato2  in  32  store data.
REQ-011 i_DirWriteReg  in  5  destination register.
REQ-012 mem_req  out  1; mem_we  out  1; mem_addr  out  32; mem_wdata  out  32  data-memory request.
REQ-013 mem_ack  in  1; mem_rdata  in  32  data-memory completion and read data.
REQ-014 O_PCSrc  out  1; O_BranchTarget  out  32  branch resolution to fetch.
REQ-015 O_Stall  out  1  freeze upstream stages and EX/MEM.
REQ-016 O_Valid  out  1; O_WB  out  2; O_ReadData  out  32; O_ALUresult  out  32; O_DirWriteReg  out  5  MEM/WB register.
REQ-017 O_MemErr  out  1  one-cycle pulse on misaligned access or timeout.

Function
REQ-018 FSM states IDLE and ACCESS only.
REQ-019 "mem op": i_valid & (i_MemRead | i_MemWrite); i_MemWrite wins when both set.
REQ-020 IDLE, no mem op: MEM/WB register loads inputs at the next edge, O_ReadData=0, O_Valid=i_valid; latency 1 cycle; O_Stall=0.
REQ-021 IDLE, mem op, i_ALUresult[1:0]==0: O_Stall=1 combinationally; next edge ACCESS, capture mem_addr=i_ALUresult, mem_wdata=i_Dato2, mem_we=i_MemWrite, and controls; MEM/WB loads a bubble (O_Valid=0, O_WB=0).
REQ-022 IDLE, mem op, i_ALUresult[1:0]!=0: no request; O_Stall=0; next edge MEM/WB loads with O_WB=0, O_Valid=1, O_MemErr=1 for one cycle.
REQ-023 ACCESS: mem_req=1; mem_addr, mem_wdata, mem_we stable until the handshake completes.
REQ-024 ACCESS, mem_ack=1: O_Stall=0 that cycle; next edge MEM/WB loads captured controls, O_ReadData=mem_rdata (0 for stores), O_Valid=1, mem_req=0, state IDLE.
REQ-025 ACCESS, mem_ack=0: O_Stall=1; wait counter increments, starting from 1 on the first ACCESS cycle.
REQ-026 Counter==MEM_TIMEOUT and mem_ack=0: abort; O_Stall=0; next edge mem_req=0, IDLE, MEM/WB loads with O_WB=0, O_Valid=1, O_MemErr pulses.
REQ-027 mem_ack and timeout in the same cycle: mem_ack wins, no error.
REQ-028 mem_ack in IDLE: ignored, no state change.
REQ-029 O_PCSrc = i_valid & i_Branch & i_ZeroFlag & ~O_Stall, combinational; O_BranchTarget = i_BranchInst.
REQ-030 Minimum load-to-load throughput: 2 cycles (IDLE->ACCESS->IDLE) with zero-wait mem_ack.

Reset
REQ-031 rst at a clock edge: state IDLE, counter 0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, all MEM/WB outputs 0, O_MemErr=0.
REQ-032 rst during ACCESS: mem_req drops at that edge, the pending access is discarded, and a late mem_ack is ignored.
REQ-033 O_Stall and O_PCSrc are 0 while rst=1.

Verification
REQ-034 ALU op (WB=01, ALUresult=0x10, reg 5) -> next cycle O_Valid=1, O_ALUresult=0x10, O_DirWriteReg=5, O_Stall never 1.
REQ-035 Load addr 0x100 with mem_ack 3 cycles after mem_req -> O_Stall high 4 cycles; mem_rdata=0xDEADBEEF lands in O_ReadData; O_WB=11.
REQ-036 Store addr 0x202 -> no mem_req; O_MemErr pulse; O_WB=00.
REQ-037 MEM_TIMEOUT=4, load with no ack -> mem_req high exactly 4 cycles, then O_MemErr pulse and O_WB=00; with ack on the 4th cycle -> normal completion.
REQ-038 Branch=1, Zero=1, target 0x400 -> O_PCSrc=1 and O_BranchTarget=0x400 same cycle; Zero=0 -> O_PCSrc=0.
REQ-039 rst asserted during the 2nd ACCESS cycle -> mem_req=0 next cycle, outputs 0, and an ack one cycle later causes no MEM/WB load.
